// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: pipeline write-back has priority, and auxiliary
// results wait in a small FIFO that drains into idle slots or into a forced freeze cycle.
module wb_write_arbiter #(
  parameter int WORD_LENGTH  = 32,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wb_enable_in,
  input  logic [3:0]             wb_dest_in,
  input  logic [WORD_LENGTH-1:0] wb_value_in,
  input  logic                   aux_valid,
  output logic                   aux_ready,
  input  logic [3:0]             aux_dest,
  input  logic [WORD_LENGTH-1:0] aux_value,
  output logic                   rf_we,
  output logic [3:0]             rf_dest,
  output logic [WORD_LENGTH-1:0] rf_value,
  output logic                   freeze,
  output logic                   aux_pending
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  logic [3:0]             dest_mem  [DEPTH];
  logic [WORD_LENGTH-1:0] value_mem [DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [CW-1:0]          count;
  logic [SW-1:0]          starve_cnt;
  logic                   fifo_empty;
  logic                   push;
  logic                   pop;
  logic                   freeze_next;

  assign fifo_empty  = (count == '0);
  assign aux_pending = ~fifo_empty;
  // Registered count only, so the same-cycle pop never opens a slot early.
  assign aux_ready   = (count < CW'(DEPTH));
  assign push        = aux_valid & aux_ready;

  always_comb begin
    pop      = 1'b0;
    rf_we    = wb_enable_in;
    rf_dest  = wb_dest_in;
    rf_value = wb_value_in;
    if (freeze) begin
      rf_we = ~fifo_empty;
      pop   = ~fifo_empty;
    end else if (!wb_enable_in && !fifo_empty) begin
      rf_we = 1'b1;
      pop   = 1'b1;
    end
    if (pop) begin
      rf_dest  = dest_mem[rd_ptr];
      rf_value = value_mem[rd_ptr];
    end
  end

  // The ~freeze term keeps the stall a single-cycle pulse even if a head survives it.
  assign freeze_next = ~fifo_empty & ~pop & ~freeze &
                       (starve_cnt == SW'(STARVE_LIMIT - 1));

  always_ff @(posedge clk) begin
    if (push) begin
      dest_mem[wr_ptr]  <= aux_dest;
      value_mem[wr_ptr] <= aux_value;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      freeze     <= 1'b0;
    end else begin
      freeze <= freeze_next;
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (fifo_empty || pop || freeze) begin
        starve_cnt <= '0;
      end else begin
        starve_cnt <= starve_cnt + SW'(1);
      end
    end
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter: grant priority, FIFO drain, starvation freeze, reset.
module tb_wb_write_arbiter;

  localparam int WL = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          wb_enable_in;
  logic [3:0]    wb_dest_in;
  logic [WL-1:0] wb_value_in;
  logic          aux_valid;
  logic          aux_ready;
  logic [3:0]    aux_dest;
  logic [WL-1:0] aux_value;
  logic          rf_we;
  logic [3:0]    rf_dest;
  logic [WL-1:0] rf_value;
  logic          freeze;
  logic          aux_pending;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_write_arbiter #(.WORD_LENGTH(WL), .DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .wb_enable_in(wb_enable_in), .wb_dest_in(wb_dest_in), .wb_value_in(wb_value_in),
    .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_dest(aux_dest), .aux_value(aux_value),
    .rf_we(rf_we), .rf_dest(rf_dest), .rf_value(rf_value),
    .freeze(freeze), .aux_pending(aux_pending)
  );

  // Advance past the next rising edge; inputs are changed here, outputs sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wb_enable_in = 1'b0; wb_dest_in = 4'd0; wb_value_in = '0;
    aux_valid = 1'b0; aux_dest = 4'd0; aux_value = '0;
    step(); step(); #1;
    n_checks++; if (aux_pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending: got %b want 0", aux_pending); end
    n_checks++; if (aux_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", aux_ready); end
    n_checks++; if (freeze !== 1'b0) begin n_fail++; $display("FAIL reset_freeze: got %b want 0", freeze); end
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", rf_we); end
    wb_enable_in = 1'b1; wb_dest_in = 4'd9; #1;
    n_checks++; if (rf_we !== 1'b1 || rf_dest !== 4'd9) begin n_fail++; $display("FAIL reset_passthru: got we=%b dest=%0d want we=1 dest=9", rf_we, rf_dest); end
    step();
    rst = 1'b0; wb_enable_in = 1'b0;
  endtask

  task automatic test_idle_aux();
    aux_valid = 1'b1; aux_dest = 4'd5; aux_value = 32'hDEADBEEF; #1;
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL idle_nobypass: got we=%b want 0", rf_we); end
    step();
    aux_valid = 1'b0; #1;
    n_checks++; if (rf_we !== 1'b1 || rf_dest !== 4'd5 || rf_value !== 32'hDEADBEEF)
      begin n_fail++; $display("FAIL idle_write: got we=%b dest=%0d val=%h want we=1 dest=5 val=deadbeef", rf_we, rf_dest, rf_value); end
    n_checks++; if (aux_pending !== 1'b1) begin n_fail++; $display("FAIL idle_pending1: got %b want 1", aux_pending); end
    step(); #1;
    n_checks++; if (aux_pending !== 1'b0 || rf_we !== 1'b0) begin n_fail++; $display("FAIL idle_drained: got pending=%b we=%b want 0 0", aux_pending, rf_we); end
  endtask

  task automatic test_starvation();
    wb_enable_in = 1'b1; wb_dest_in = 4'd1; wb_value_in = 32'h0000_0011;
    aux_valid = 1'b1; aux_dest = 4'd7; aux_value = 32'h0000_0077;
    step();
    aux_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      n_checks++; if (freeze !== 1'b0 || rf_we !== 1'b1 || rf_dest !== 4'd1 || rf_value !== 32'h11)
        begin n_fail++; $display("FAIL starve_pipe_c%0d: got frz=%b we=%b dest=%0d val=%h want 0 1 1 11", c, freeze, rf_we, rf_dest, rf_value); end
      step();
    end
    #1;
    n_checks++; if (freeze !== 1'b1 || rf_we !== 1'b1 || rf_dest !== 4'd7 || rf_value !== 32'h77)
      begin n_fail++; $display("FAIL starve_freeze: got frz=%b we=%b dest=%0d val=%h want 1 1 7 77", freeze, rf_we, rf_dest, rf_value); end
    step(); #1;
    n_checks++; if (freeze !== 1'b0 || rf_dest !== 4'd1 || aux_pending !== 1'b0)
      begin n_fail++; $display("FAIL starve_after: got frz=%b dest=%0d pending=%b want 0 1 0", freeze, rf_dest, aux_pending); end
    wb_enable_in = 1'b0;
    step();
  endtask

  task automatic test_fill();
    wb_enable_in = 1'b1; wb_dest_in = 4'd1; wb_value_in = 32'h11;
    aux_valid = 1'b1; aux_dest = 4'd2; aux_value = 32'h22;
    step();
    aux_dest = 4'd3; aux_value = 32'h33; #1;
    n_checks++; if (aux_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready1: got %b want 1", aux_ready); end
    step();
    aux_dest = 4'd4; aux_value = 32'h44;
    for (int c = 2; c <= 4; c++) begin
      #1;
      n_checks++; if (aux_ready !== 1'b0 || freeze !== 1'b0) begin n_fail++; $display("FAIL fill_full_c%0d: got ready=%b frz=%b want 0 0", c, aux_ready, freeze); end
      step();
    end
    #1;
    n_checks++; if (freeze !== 1'b1 || rf_dest !== 4'd2 || aux_ready !== 1'b0)
      begin n_fail++; $display("FAIL fill_freeze: got frz=%b dest=%0d ready=%b want 1 2 0", freeze, rf_dest, aux_ready); end
    step(); #1;
    n_checks++; if (aux_ready !== 1'b1 || freeze !== 1'b0 || rf_dest !== 4'd1)
      begin n_fail++; $display("FAIL fill_reopen: got ready=%b frz=%b dest=%0d want 1 0 1", aux_ready, freeze, rf_dest); end
    step();
    aux_valid = 1'b0; wb_enable_in = 1'b0; #1;
    n_checks++; if (rf_we !== 1'b1 || rf_dest !== 4'd3 || rf_value !== 32'h33)
      begin n_fail++; $display("FAIL fill_drain_b: got we=%b dest=%0d val=%h want 1 3 33", rf_we, rf_dest, rf_value); end
    step(); #1;
    n_checks++; if (rf_we !== 1'b1 || rf_dest !== 4'd4 || rf_value !== 32'h44)
      begin n_fail++; $display("FAIL fill_drain_c: got we=%b dest=%0d val=%h want 1 4 44", rf_we, rf_dest, rf_value); end
    step(); #1;
    n_checks++; if (aux_pending !== 1'b0 || rf_we !== 1'b0) begin n_fail++; $display("FAIL fill_empty: got pending=%b we=%b want 0 0", aux_pending, rf_we); end
  endtask

  task automatic test_wrap();
    logic [3:0]    exp_dest;
    logic [WL-1:0] exp_val;
    wb_enable_in = 1'b0;
    aux_valid = 1'b1; aux_dest = 4'd8; aux_value = 32'hA000_0008;
    step();
    for (int k = 1; k <= 5; k++) begin
      exp_dest = 4'(7 + k);
      exp_val  = 32'hA000_0000 | WL'(7 + k);
      if (k < 5) begin
        aux_dest = 4'(8 + k); aux_value = 32'hA000_0000 | WL'(8 + k);
      end else begin
        aux_valid = 1'b0;
      end
      #1;
      n_checks++; if (rf_we !== 1'b1 || rf_dest !== exp_dest || rf_value !== exp_val)
        begin n_fail++; $display("FAIL wrap_order_%0d: got we=%b dest=%0d val=%h want 1 %0d %h", k, rf_we, rf_dest, rf_value, exp_dest, exp_val); end
      n_checks++; if (aux_pending !== 1'b1 || aux_ready !== 1'b1)
        begin n_fail++; $display("FAIL wrap_count_%0d: got pending=%b ready=%b want 1 1", k, aux_pending, aux_ready); end
      step();
    end
    #1;
    n_checks++; if (aux_pending !== 1'b0) begin n_fail++; $display("FAIL wrap_empty: got %b want 0", aux_pending); end
  endtask

  task automatic test_reset_mid();
    wb_enable_in = 1'b1; wb_dest_in = 4'd1;
    aux_valid = 1'b1; aux_dest = 4'd13; aux_value = 32'hD;
    step();
    aux_dest = 4'd14; aux_value = 32'hE;
    step();
    aux_valid = 1'b0; #1;
    n_checks++; if (aux_ready !== 1'b0 || aux_pending !== 1'b1) begin n_fail++; $display("FAIL rstmid_full: got ready=%b pending=%b want 0 1", aux_ready, aux_pending); end
    rst = 1'b1; wb_enable_in = 1'b0;
    step(); #1;
    n_checks++; if (aux_pending !== 1'b0 || freeze !== 1'b0 || aux_ready !== 1'b1)
      begin n_fail++; $display("FAIL rstmid_cleared: got pending=%b frz=%b ready=%b want 0 0 1", aux_pending, freeze, aux_ready); end
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      n_checks++; if (rf_we !== 1'b0 || freeze !== 1'b0) begin n_fail++; $display("FAIL rstmid_nowrite_%0d: got we=%b frz=%b want 0 0", c, rf_we, freeze); end
      step();
    end
  endtask

  task automatic test_alternate();
    wb_enable_in = 1'b1; wb_dest_in = 4'd1; wb_value_in = 32'h11;
    aux_valid = 1'b1; aux_dest = 4'd5; aux_value = 32'h55;
    step();
    aux_dest = 4'd6; aux_value = 32'h66; #1;
    n_checks++; if (freeze !== 1'b0 || rf_dest !== 4'd1) begin n_fail++; $display("FAIL alt_c1: got frz=%b dest=%0d want 0 1", freeze, rf_dest); end
    step();
    aux_valid = 1'b0; wb_enable_in = 1'b0; #1;
    n_checks++; if (freeze !== 1'b0 || rf_we !== 1'b1 || rf_dest !== 4'd5 || rf_value !== 32'h55)
      begin n_fail++; $display("FAIL alt_slot1: got frz=%b we=%b dest=%0d val=%h want 0 1 5 55", freeze, rf_we, rf_dest, rf_value); end
    step();
    wb_enable_in = 1'b1; #1;
    n_checks++; if (freeze !== 1'b0 || rf_dest !== 4'd1 || aux_pending !== 1'b1)
      begin n_fail++; $display("FAIL alt_c3: got frz=%b dest=%0d pending=%b want 0 1 1", freeze, rf_dest, aux_pending); end
    step();
    wb_enable_in = 1'b0; #1;
    n_checks++; if (freeze !== 1'b0 || rf_we !== 1'b1 || rf_dest !== 4'd6 || rf_value !== 32'h66)
      begin n_fail++; $display("FAIL alt_slot2: got frz=%b we=%b dest=%0d val=%h want 0 1 6 66", freeze, rf_we, rf_dest, rf_value); end
    step(); #1;
    n_checks++; if (freeze !== 1'b0 || aux_pending !== 1'b0) begin n_fail++; $display("FAIL alt_done: got frz=%b pending=%b want 0 0", freeze, aux_pending); end
  endtask

  initial begin
    test_reset();
    test_idle_aux();
    test_starvation();
    test_fill();
    test_wrap();
    test_reset_mid();
    test_alternate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_write_arbiter.md
# wb_write_arbiter

Arbitrates the single register-file write port between the pipeline write-back path and an auxiliary long-latency requester, such as a multi-cycle multiplier or an external-memory load unit. Auxiliary results are buffered in a small FIFO and drained into idle write-back slots. If the pipeline keeps the port busy too long, the block raises a one-cycle freeze that stalls MEM/WB and forces a drain. It sits between the WB stage outputs and the register file write inputs.

## Interface
Parameters:
- WORD_LENGTH, 32, data width of write values
- DEPTH, 2, auxiliary FIFO entries (power of two, ≥2)
- STARVE_LIMIT, 4, consecutive unserviced cycles of a FIFO head before freeze (≥1)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- wb_enable_in  in  1  pipeline write-back request (from WB stage)
- wb_dest_in  in  4  pipeline destination register
- wb_value_in  in  WORD_LENGTH  pipeline write value
- aux_valid  in  1  auxiliary result valid
- aux_ready  out  1  FIFO can accept (count < DEPTH)
- aux_dest  in  4  auxiliary destination register
- aux_value  in  WORD_LENGTH  auxiliary write value
- rf_we  out  1  register-file write enable
- rf_dest  out  4  register-file write address
- rf_value  out  WORD_LENGTH  register-file write data
- freeze  out  1  registered; stalls the MEM/WB register for one cycle
- aux_pending  out  1  FIFO non-empty

## Operation
- Accept: push happens when aux_valid & aux_ready at the clock edge. There is no bypass; an accepted entry reaches the port no earlier than the next cycle.
- Grant, combinational each cycle:
  - freeze=1: grant FIFO head if non-empty, else rf_we=0. wb_enable_in is ignored.
  - else wb_enable_in=1: grant pipeline (rf_* = wb_*_in).
  - else FIFO non-empty: grant head (pop).
  - else rf_we=0. rf_dest and rf_value = pipeline inputs.
- Pop happens only when the head is granted. Push and pop in the same cycle are legal, and count is unchanged.
- aux_ready depends on registered count only. It does not depend on the same-cycle pop.
- Starvation counter:
  - Clears when the FIFO is empty, on a pop, or when freeze is set.
  - Otherwise increments each cycle the FIFO is non-empty and not popped.
  - freeze_next = non-empty & ~pop & (starve_cnt == STARVE_LIMIT-1).
- freeze is a one-cycle pulse. It cannot assert two consecutive cycles.
- Correctness of freeze: the pipeline instruction presented during the freeze cycle is held by MEM/WB and re-presented the next cycle, so it is never lost.
- Register hazards between aux writes and pipeline reads are the issuer's responsibility.
- Same-destination ordering is the issuer's responsibility.

## Timing
- Reset values: FIFO empty, count=0, starve_cnt=0, freeze=0, aux_pending=0, aux_ready=1. rf_we=wb_enable_in, which is 0 under a reset-held pipeline.
- Reset mid-operation discards all buffered entries. No write is issued for them.
- Latency, pipeline: 0 cycles (combinational pass-through).
- Latency, aux on an idle port: accept at edge t, written in cycle t+1.
- Worst-case aux head wait: STARVE_LIMIT cycles unserviced, then drained in the freeze cycle (STARVE_LIMIT+1 cycles after becoming head).
- Full FIFO: aux_ready=0. aux_valid is ignored and the requester must hold.
- Wrap-around: read and write pointers are log2(DEPTH) bits, wrapping naturally. Count is log2(DEPTH)+1 bits.

## Test plan
- Idle pipeline, aux push dest=5 value=0xDEADBEEF at edge 0 -> cycle 1: rf_we=1, rf_dest=5, rf_value=0xDEADBEEF. aux_pending drops after edge 1.
- Pipeline writes dest=1 every cycle; aux push at edge 0 -> cycles 1–4 pipeline granted, freeze=1 in cycle 5 with aux entry written. Pipeline instruction re-presented and written in cycle 6. freeze=0 in cycle 6.
- Fill FIFO (DEPTH=2) with pipeline busy -> aux_ready=0 after second accept. A third aux_valid is not accepted until the first pop.
- Simultaneous push and pop with count=1 -> count stays 1, entries written in FIFO order across ≥4 pushes (pointer wrap).
- Assert rst with 2 entries buffered -> next cycle aux_pending=0, freeze=0, aux_ready=1. No aux write ever appears.
- Pipeline idle on alternate cycles with FIFO holding 2 entries -> both drained in the idle slots. freeze never asserts.
